// File: rtl/lcd_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_msg_arbiter
// Description : Shares one character-LCD driver between two message
//               requesters. Plays the LCD power-on command sequence after
//               reset, then grants requesters round-robin and streams each
//               message as one set-DDRAM-address command plus CHARS data
//               bytes over a valid/ready command port.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_msg_arbiter #(
    parameter int          CHARS      = 4,
    parameter logic [7:0]  LINE0_ADDR = 8'h80,
    parameter logic [7:0]  LINE1_ADDR = 8'hC0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_i,
    input  logic                 req1_i,
    input  logic [8*CHARS-1:0]   msg0_i,
    input  logic [8*CHARS-1:0]   msg1_i,
    output logic                 ack0_o,
    output logic                 ack1_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic                 cmd_rs_o,
    output logic [7:0]           cmd_byte_o,
    output logic                 grant_o,
    output logic                 busy_o,
    output logic                 init_done_o
);

    localparam int c_MSG_W = 8 * CHARS;
    localparam int c_CNT_W = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CHAR = c_CNT_W'(CHARS - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_ADDR = 3'd2,
        ST_CHAR = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           init_idx_q, init_idx_d;
    logic [c_CNT_W-1:0]   char_cnt_q, char_cnt_d;
    logic [c_MSG_W-1:0]   shift_q, shift_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic                 init_done_q, init_done_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 cmd_rs_q, cmd_rs_d;
    logic [7:0]           cmd_byte_q, cmd_byte_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;

    logic                 w_xfer;
    logic                 w_winner;
    logic [c_MSG_W-1:0]   w_msg_sel;
    logic [c_MSG_W-1:0]   w_shift_next;

    // LCD power-on sequence: function set, display on, clear, entry mode
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    // Tie goes to the requester not served last; a lone request always wins
    assign w_xfer       = cmd_valid_q & cmd_ready_i;
    assign w_winner     = (req0_i & req1_i) ? ~last_q : req1_i;
    assign w_msg_sel    = w_winner ? msg1_i : msg0_i;
    assign w_shift_next = shift_q << 8;

    // State and registered-output update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            init_idx_q  <= 2'd0;
            char_cnt_q  <= '0;
            shift_q     <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            init_done_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_rs_q    <= 1'b0;
            cmd_byte_q  <= 8'h00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            char_cnt_q  <= char_cnt_d;
            shift_q     <= shift_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_rs_q    <= cmd_rs_d;
            cmd_byte_q  <= cmd_byte_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic; command word only moves on a transfer
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        char_cnt_d  = char_cnt_q;
        shift_d     = shift_q;
        grant_d     = grant_q;
        last_d      = last_q;
        init_done_d = init_done_q;
        cmd_valid_d = cmd_valid_q;
        cmd_rs_d    = cmd_rs_q;
        cmd_byte_d  = cmd_byte_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_INIT: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_rs_d    = 1'b0;
                    cmd_byte_d  = init_cmd(init_idx_q);
                end else if (w_xfer) begin
                    if (init_idx_q == 2'd3) begin
                        cmd_valid_d = 1'b0;
                        init_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        init_idx_d  = init_idx_q + 2'd1;
                        cmd_byte_d  = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end

            ST_IDLE: begin
                cmd_valid_d = 1'b0;
                if (req0_i | req1_i) begin
                    grant_d     = w_winner;
                    shift_d     = w_msg_sel;
                    cmd_valid_d = 1'b1;
                    cmd_rs_d    = 1'b0;
                    cmd_byte_d  = w_winner ? LINE1_ADDR : LINE0_ADDR;
                    busy_d      = 1'b1;
                    state_d     = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (w_xfer) begin
                    char_cnt_d = '0;
                    cmd_rs_d   = 1'b1;
                    cmd_byte_d = shift_q[c_MSG_W-1 -: 8];
                    state_d    = ST_CHAR;
                end
            end

            ST_CHAR: begin
                if (w_xfer) begin
                    shift_d    = w_shift_next;
                    char_cnt_d = char_cnt_q + c_CNT_W'(1);
                    if (char_cnt_q == c_LAST_CHAR) begin
                        cmd_valid_d = 1'b0;
                        ack0_d      = ~grant_q;
                        ack1_d      = grant_q;
                        state_d     = ST_DONE;
                    end else begin
                        cmd_byte_d  = w_shift_next[c_MSG_W-1 -: 8];
                    end
                end
            end

            ST_DONE: begin
                last_d  = grant_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_rs_o    = cmd_rs_q;
    assign cmd_byte_o  = cmd_byte_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign init_done_o = init_done_q;

endmodule
`default_nettype wire

// File: doc/lcd_msg_arbiter.md
# lcd_msg_arbiter

Shares the single character-LCD driver between two message requesters: the live-temperature line and the running-average line. After reset it runs the LCD power-on command sequence. It then grants requesters round-robin and streams each granted message to the driver over a valid/ready command port: one DDRAM set-address command followed by CHARS character bytes. It sits between the temperature/average formatting logic and the LCD driver, and replaces fixed instruction-memory sequencing.

## Interface
Parameters:
- CHARS, 4, characters per message (sign, hundreds, tens, units)
- LINE0_ADDR, 8'h80, set-DDRAM command for requester 0 (line 1, column 0)
- LINE1_ADDR, 8'hC0, set-DDRAM command for requester 1 (line 2, column 0)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0, req1  in  1  message request (level), held until matching ack
- msg0, msg1  in  8*CHARS  ASCII payload; bits [8*CHARS-1 -: 8] sent first; sampled at grant only
- ack0, ack1  out  1  one-cycle pulse: message fully transferred
- cmd_valid  out  1  command word valid to LCD driver
- cmd_ready  in  1  driver accepts command word this cycle
- cmd_rs  out  1  0 = instruction, 1 = character data
- cmd_byte  out  8  instruction or character byte
- grant  out  1  requester currently in service (0/1), valid while busy and init_done
- busy  out  1  high in every state except IDLE
- init_done  out  1  high once the init sequence has completed; stays high until reset

## Operation
- States: INIT, IDLE, ADDR, CHAR, DONE. All outputs are registered.
- Transfer: occurs on a rising edge with cmd_valid=1 and cmd_ready=1. While cmd_valid=1 and cmd_ready=0, cmd_rs and cmd_byte are held stable. cmd_valid never drops without a transfer.
- INIT: sends 4 instructions (RS=0) in order: 0x38, 0x0C, 0x01, 0x06. After the 4th transfer: init_done=1, go to IDLE. Requests arriving during INIT stay pending and are not lost.
- IDLE: cmd_valid=0. If any req is high, pick a winner:
  - If only one req is high, it wins.
  - If both are high, the requester not served last wins. The last-served pointer resets to 1, so req0 wins the first tie.
  - On the grant edge: latch the winner's msg into an internal shift register, set grant, go to ADDR.
- ADDR: cmd_rs=0, cmd_byte=LINE0_ADDR or LINE1_ADDR by grant. On transfer go to CHAR with char count=0.
- CHAR: cmd_rs=1, cmd_byte = current top byte of the latched message. On each transfer, shift and increment the count. On the transfer of character CHARS-1 go to DONE.
- DONE: cmd_valid=0; ack[grant]=1 for exactly one cycle; update last-served pointer; go to IDLE.
- Changes to msg after the grant do not affect the in-flight message.
- A req still high in the IDLE cycle after ack counts as a new request.
- Dropping req mid-message does not abort; the message completes and ack still pulses.
- Reset asserted in any state: asynchronously clear all outputs and return to INIT. No ack is issued for an aborted message. The last-served pointer returns to 1.

## Timing
- Reset values: cmd_valid=0, cmd_rs=0, cmd_byte=8'h00, ack0=ack1=0, grant=0, busy=1, init_done=0.
- Init, edges numbered from the first edge after rst deasserts (E1):
  - E1: cmd_valid=1, cmd_byte=0x38.
  - With cmd_ready=1, transfers occur at E2..E5.
  - init_done=1, busy=0, cmd_valid=0 after E5.
- Message, with a req high before edge Ei in IDLE and cmd_ready tied high:
  - Ei: grant set, cmd_valid=1, address command on the bus.
  - Transfers at Ei+1 (address) and Ei+2..Ei+5 (characters).
  - After Ei+5: DONE, ack pulse high.
  - After Ei+6: IDLE.
  - The next grant is possible at Ei+7.
- Each low cycle of cmd_ready adds exactly one cycle of latency. There is no timeout.

## Test plan
- Reset release with cmd_ready=1 -> bytes 0x38, 0x0C, 0x01, 0x06 with RS=0 at E2..E5; init_done=1 after E5; no ack.
- req0 with msg0="+025" (0x2B,0x30,0x32,0x35), ready=1 -> stream 0x80(RS0), 0x2B, 0x30, 0x32, 0x35(RS1); ack0 pulses one cycle exactly 6 cycles after grant edge.
- req0 and req1 both high at IDLE, held continuously -> service order 0, 1, 0, 1; req1 stream starts with 0xC0; acks alternate.
- cmd_ready toggling 1,0,0,1 during CHAR -> cmd_byte stable while stalled; no byte skipped or duplicated; latency grows by the stall count.
- msg1 changed from "-040" to "+085" one cycle after grant -> "-040" is transmitted.
- rst asserted while in CHAR after 2 characters -> outputs go to reset values immediately; no ack; after release the init sequence replays, then a pending req1 is served in full.
